// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// State encodings are fixed so the stage registers and debug logic can decode them.
package pipeline_stall_controller_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_ERROR    = 2'd3
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_write;
    logic mem_wb_bubble;
  } ctrl_t;

  localparam ctrl_t CTRL_OFF    = '{default: 1'b0};
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                    id_ex_write: 1'b1, id_ex_bubble: 1'b0,
                                    ex_mem_write: 1'b1, mem_wb_bubble: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_write: 1'b0, id_ex_bubble: 1'b0,
                                    ex_mem_write: 1'b0, mem_wb_bubble: 1'b1};

endpackage

// File: rtl/load_use_compare.sv
// Combinational load-use hazard detect between the load in EX and the sources in ID.
// A load targeting x0 never creates a dependency.
module load_use_compare
  import pipeline_stall_controller_pkg::*;
(
  input  logic             mem_read_i,
  input  logic [REG_W-1:0] rd_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  output logic             load_use_o
);

  assign load_use_o = mem_read_i && (rd_i != REG_X0) && ((rd_i == rs1_i) || (rd_i == rs2_i));

endmodule

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer: merges memory freeze, load-use and taken-branch hazards into
// per-stage enables, tracks memory-wait timeout and keeps saturating stall counters.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             ID_EX_MemRead_i,
  input  logic [REG_W-1:0] ID_EX_RegisterRd_i,
  input  logic [REG_W-1:0] IF_ID_RegisterRs1_i,
  input  logic [REG_W-1:0] IF_ID_RegisterRs2_i,
  input  logic             branch_taken_i,
  input  logic             EX_MEM_MemAccess_i,
  input  logic             dcache_ack_i,
  output logic             PCWrite_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Write_o,
  output logic             ID_EX_Bubble_o,
  output logic             EX_MEM_Write_o,
  output logic             MEM_WB_Bubble_o,
  output logic             error_o,
  output logic [CNT_W-1:0] loaduse_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] loaduse_cnt_q, loaduse_cnt_d;
  logic [CNT_W-1:0] memwait_cnt_q, memwait_cnt_d;
  logic             error_q, error_d;
  logic             load_use;
  logic             freeze;
  ctrl_t            ctrl;

  load_use_compare u_load_use_compare (
    .mem_read_i (ID_EX_MemRead_i),
    .rd_i       (ID_EX_RegisterRd_i),
    .rs1_i      (IF_ID_RegisterRs1_i),
    .rs2_i      (IF_ID_RegisterRs2_i),
    .load_use_o (load_use)
  );

  assign freeze = ((state_q == ST_MEM_WAIT) && !dcache_ack_i)
               || ((state_q == ST_RUN) && EX_MEM_MemAccess_i && !dcache_ack_i);

  // Priority mux: freeze holds IF/ID and ID/EX, so load-use and branch are
  // naturally re-evaluated once the memory access completes.
  always_comb begin
    ctrl = CTRL_OFF;
    if ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) begin
      if (freeze) begin
        ctrl = CTRL_FREEZE;
      end else if (load_use) begin
        ctrl              = CTRL_RUN;
        ctrl.pc_write     = 1'b0;
        ctrl.if_id_write  = 1'b0;
        ctrl.id_ex_bubble = 1'b1;
      end else if (branch_taken_i) begin
        ctrl             = CTRL_RUN;
        ctrl.if_id_flush = 1'b1;
      end else begin
        ctrl = CTRL_RUN;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (EX_MEM_MemAccess_i && !dcache_ack_i) begin
          state_d = ST_MEM_WAIT;
          wait_d  = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (dcache_ack_i) begin
          state_d = ST_RUN;
        end else if (wait_q == TIMEOUT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_ERROR;
    endcase
  end

  always_comb begin
    loaduse_cnt_d = loaduse_cnt_q;
    memwait_cnt_d = memwait_cnt_q;
    error_d       = error_q || (state_d == ST_ERROR);
    if ((state_q == ST_RUN) && load_use && !freeze && (loaduse_cnt_q != CNT_MAX))
      loaduse_cnt_d = loaduse_cnt_q + 1'b1;
    if (freeze && (memwait_cnt_q != CNT_MAX))
      memwait_cnt_d = memwait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      wait_q        <= '0;
      loaduse_cnt_q <= '0;
      memwait_cnt_q <= '0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      loaduse_cnt_q <= loaduse_cnt_d;
      memwait_cnt_q <= memwait_cnt_d;
      error_q       <= error_d;
    end
  end

  assign PCWrite_o       = ctrl.pc_write;
  assign IF_ID_Write_o   = ctrl.if_id_write;
  assign IF_ID_Flush_o   = ctrl.if_id_flush;
  assign ID_EX_Write_o   = ctrl.id_ex_write;
  assign ID_EX_Bubble_o  = ctrl.id_ex_bubble;
  assign EX_MEM_Write_o  = ctrl.ex_mem_write;
  assign MEM_WB_Bubble_o = ctrl.mem_wb_bubble;
  assign error_o         = error_q;
  assign loaduse_cnt_o   = loaduse_cnt_q;
  assign memwait_cnt_o   = memwait_cnt_q;

endmodule
